i2c_regbank_slave: RTL
======================

Name: i2c_regbank_slave

Overview:
- Parametrised I2C target that replaces the fixed write-only slave in the dice project.
- Supports a configurable 7-bit address, a configurable register count, auto-incrementing sub-address, write and read transactions, and repeated START.
- Sits between the uio pads (SCL/SDA, open-drain) and the dice core, which consumes register contents and supplies live read-back data.
- Fully synchronous to the system clock; SCL/SDA are oversampled.

Parameters:
- I2C_ADDR, 7'h70: 7-bit target address matched against the first byte after START.
- NREGS, 16: number of 8-bit registers, 2..256. The pointer width PW = max(1, clog2(NREGS)).
- SYNC_STAGES, 2: synchroniser flops on SCL and SDA, minimum 2.
- RESET_VAL, 8'h00: reset value of every register.

Ports:
- clk, input, 1: system clock. Must be at least 10x the SCL frequency.
- rst_n, input, 1: reset, asynchronous assert, active-low.
- ena, input, 1: block enable. When low: FSM held in IDLE, sda_oe=0, registers retained.
- scl_in, input, 1: raw SCL pad input.
- sda_in, input, 1: raw SDA pad input.
- sda_oe, output, 1: 1 = pull SDA low. The pad drives 0 through the output enable and never drives high.
- regs_q, output, 8*NREGS: flattened register file, reg k at bits [8k+7:8k].
- wr_stb, output, 1: one-clk pulse per accepted data byte.
- wr_addr, output, PW: register index written, valid with wr_stb.
- wr_data, output, 8: byte written, valid with wr_stb.
- rd_addr, output, PW: current read pointer, driven continuously.
- rd_data, input, 8: read-back byte for rd_addr. External combinational mux, sampled by this block.

Behaviour:
- Reset values:
  - FSM = IDLE, sda_oe=0, wr_stb=0, wr_addr=0, wr_data=0, rd_addr=0.
  - Every register = RESET_VAL.
  - Synchronisers preset to 1 (bus idle).
- Input conditioning:
  - SCL and SDA each pass SYNC_STAGES flops, then one extra flop for edge detection.
  - Total input latency is SYNC_STAGES+1 clk.
- Bus conditions, detected on the synchronised signals:
  - START (or repeated START): SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Data is sampled on the SCL rising edge, MSB first.
  - sda_oe changes only on the clk after an SCL falling edge is detected.
- FSM states: IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE.
- Bit counting: a 3-bit counter counts 8 bits per byte state. The ACK slot is the 9th SCL pulse.
- Transitions:
  - START from any state → ADDR, bit counter cleared. This includes a repeated START in the middle of a byte.
  - STOP from any state → IDLE, sda_oe=0 on the next clk.
  - ADDR, 8 bits received:
    - addr[7:1]==I2C_ADDR → ADDR_ACK, sda_oe=1 for the 9th SCL pulse.
    - Mismatch → IGNORE with no ACK, waiting for START or STOP.
  - ADDR_ACK, on the falling edge ending the ACK:
    - R/W=0 → SUB.
    - R/W=1 → RD, with rd_data latched into the shift register on the same clk.
  - SUB, 8 bits received:
    - Value < NREGS → pointer loaded, ACK, then WR.
    - Value ≥ NREGS → NAK, then IGNORE; pointer unchanged.
  - WR, 8 bits received:
    - regs[ptr] is updated.
    - wr_stb pulses with wr_addr=ptr and wr_data=byte, in the clk the 8th rising edge is detected.
    - ACK follows, then WR again.
    - ptr increments, wrapping NREGS-1 → 0.
  - RD:
    - Shift-register MSB is driven on sda_oe (oe = ~bit) after each SCL falling edge.
    - After 8 bits, sda_oe is released for the master's ACK slot.
  - RD_ACK, sampling SDA on the 9th rising edge:
    - Master ACK (0) → ptr++ (wrap), rd_data for the new ptr latched on the falling edge, back to RD.
    - Master NAK (1) → IGNORE.
- Read pointer:
  - rd_addr always equals ptr.
  - ptr persists across transactions, so a write of only the sub-address followed by a repeated-START read returns that register.
- Simultaneous events: START/STOP detection has priority over data sampling in the same clk.
- ena deasserted mid-transaction: immediate IDLE, sda_oe=0, no further strobes.
- rst_n asserted mid-operation:
  - All state returns to reset values asynchronously.
  - Any partial byte is discarded and no wr_stb is issued.

Test Plan:
1. Write 0xE0 (0x70 with W), sub 0x0A, data 0x55, 0x1F, STOP:
   - ACK on all 4 bytes.
   - regs[10]=0x55, regs[11]=0x1F.
   - Two wr_stb pulses with (addr, data) = (10, 0x55), then (11, 0x1F).
2. Address 0xE2 (0x71, W) followed by any bytes:
   - SDA never pulled low.
   - No wr_stb; regs unchanged.
3. Read: write 0xE0, sub 0x0F, repeated START, 0xE1, read 2 bytes (ACK, then NAK), STOP, with regs preloaded [15]=0xA5, [0]=0x3C:
   - Master sees 0xA5 then 0x3C (pointer wraps 15→0).
   - sda_oe=0 after the NAK.
4. Sub-address 0x10 with NREGS=16:
   - NAK on the sub-address byte.
   - Following data ignored; no wr_stb.
5. rst_n pulled low during the 5th bit of a data byte, then released and the full write from scenario 1 repeated:
   - All regs return to 0x00 and sda_oe=0 within 0 clk.
   - The repeated write succeeds.
6. ena=0 during a valid write:
   - No ACK, no wr_stb.
   - Re-enabling, then issuing START, completes a normal write.

Source files
------------

// File: rtl/i2c_regbank_slave.sv
// I2C target with an auto-incrementing register bank and live read-back.
// SCL/SDA are oversampled on clk; SDA is driven open-drain through sda_oe.
module i2c_regbank_slave #(
    parameter logic [6:0] I2C_ADDR    = 7'h70,
    parameter int         NREGS       = 16,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] RESET_VAL   = 8'h00,
    localparam int        PW          = (NREGS > 2) ? $clog2(NREGS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               scl_in,
    input  logic               sda_in,
    output logic               sda_oe,
    output logic [8*NREGS-1:0] regs_q,
    output logic               wr_stb,
    output logic [PW-1:0]      wr_addr,
    output logic [7:0]         wr_data,
    output logic [PW-1:0]      rd_addr,
    input  logic [7:0]         rd_data
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_d, sda_d;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    state_t          state, state_n;
    logic [2:0]      bit_cnt, cnt_n;
    logic [7:0]      shift, shift_n;
    logic [PW-1:0]   ptr, ptr_n, ptr_inc;
    logic            ack_ph, ph_n;
    logic            rw, rw_n;
    logic            oe_n;
    logic            reg_we;
    logic [7:0]      rx_byte;
    logic            sub_ok;
    logic [7:0]      regs [NREGS];

    // Synchronisers idle high so a reset never fabricates a bus condition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

    assign rx_byte = {shift[6:0], sda_s};
    assign sub_ok  = {1'b0, rx_byte} < 9'(NREGS);
    assign ptr_inc = (ptr == PW'(NREGS - 1)) ? '0 : ptr + PW'(1);
    assign rd_addr = ptr;

    always_comb begin
        state_n = state;
        cnt_n   = bit_cnt;
        shift_n = shift;
        ptr_n   = ptr;
        ph_n    = ack_ph;
        rw_n    = rw;
        oe_n    = sda_oe;
        reg_we  = 1'b0;
        if (!ena) begin
            state_n = IDLE;
            oe_n    = 1'b0;
        end else if (start_det) begin
            state_n = ADDR;
            cnt_n   = 3'd0;
            ph_n    = 1'b0;
            oe_n    = 1'b0;
        end else if (stop_det) begin
            state_n = IDLE;
            oe_n    = 1'b0;
        end else begin
            case (state)
                ADDR, SUB, WR: begin
                    if (scl_rise) begin
                        shift_n = rx_byte;
                        cnt_n   = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            ph_n = 1'b0;
                            if (state == ADDR) begin
                                rw_n    = rx_byte[0];
                                state_n = (rx_byte[7:1] == I2C_ADDR) ? ADDR_ACK : IGNORE;
                            end else if (state == SUB) begin
                                if (sub_ok) begin
                                    ptr_n   = rx_byte[PW-1:0];
                                    state_n = SUB_ACK;
                                end else begin
                                    state_n = IGNORE;
                                end
                            end else begin
                                reg_we  = 1'b1;
                                ptr_n   = ptr_inc;
                                state_n = WR_ACK;
                            end
                        end
                    end
                end
                // First falling edge opens the ACK slot, the second one closes it.
                ADDR_ACK, SUB_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_ph) begin
                            ph_n = 1'b1;
                            oe_n = 1'b1;
                        end else begin
                            ph_n  = 1'b0;
                            oe_n  = 1'b0;
                            cnt_n = 3'd0;
                            if (state == ADDR_ACK && rw) begin
                                state_n = RD;
                                shift_n = rd_data;
                                oe_n    = ~rd_data[7];
                            end else if (state == ADDR_ACK) begin
                                state_n = SUB;
                            end else begin
                                state_n = WR;
                            end
                        end
                    end
                end
                RD: begin
                    if (scl_rise) begin
                        shift_n = {shift[6:0], 1'b0};
                        cnt_n   = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_n = RD_ACK;
                            ph_n    = 1'b0;
                        end
                    end else if (scl_fall) begin
                        oe_n = ~shift[7];
                    end
                end
                // Pointer moves on the master's ACK so rd_data is settled by the falling edge.
                RD_ACK: begin
                    if (scl_fall) begin
                        if (!ack_ph) begin
                            oe_n = 1'b0;
                            ph_n = 1'b1;
                        end else begin
                            state_n = RD;
                            cnt_n   = 3'd0;
                            ph_n    = 1'b0;
                            shift_n = rd_data;
                            oe_n    = ~rd_data[7];
                        end
                    end else if (scl_rise && ack_ph) begin
                        if (sda_s) begin
                            state_n = IGNORE;
                        end else begin
                            ptr_n = ptr_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
            ptr     <= '0;
            ack_ph  <= 1'b0;
            rw      <= 1'b0;
            sda_oe  <= 1'b0;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
            wr_data <= 8'h00;
            for (int k = 0; k < NREGS; k++) regs[k] <= RESET_VAL;
        end else begin
            state   <= state_n;
            bit_cnt <= cnt_n;
            shift   <= shift_n;
            ptr     <= ptr_n;
            ack_ph  <= ph_n;
            rw      <= rw_n;
            sda_oe  <= oe_n;
            wr_stb  <= reg_we;
            if (reg_we) begin
                regs[ptr] <= rx_byte;
                wr_addr   <= ptr;
                wr_data   <= rx_byte;
            end
        end
    end

    for (genvar k = 0; k < NREGS; k++) begin : g_flat
        assign regs_q[8*k +: 8] = regs[k];
    end

endmodule
